// File: rtl/seven_seg_display_scheduler_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
// The scheduler time-shares one 8-digit display between several value sources.
package seven_seg_pkg;

  localparam int DIGITS = 8;
  localparam int VAL_W  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    ALERT  = 2'd2
  } sched_state_t;

  // Width of a counter that runs 0..max_val-1; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/seven_seg_display_scheduler_rr_next_pick.sv
// Combinational wrap-around priority search: the first set mask bit at or
// after start+1, modulo N. With start=N-1 it returns the lowest set bit.
module rr_next_pick #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          found
);

  int pos;

  // The start index itself is visited last, so a lone set bit finds itself.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(start) + 1 + k) % N;
      if (!found && mask[pos]) begin
        found = 1'b1;
        idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/seven_seg_display_scheduler.sv
// Round-robin display scheduler with alert preemption and blink.
// All outputs are registered; val_out always matches cur_src_out and state.
module seven_seg_display_scheduler
  import seven_seg_pkg::*;
#(
  parameter int              NUM_SRC      = 4,
  parameter int              DWELL_CYCLES = 100_000_000,
  parameter int              ALERT_CYCLES = 50_000_000,
  parameter int              BLINK_HALF   = 6_250_000,
  parameter logic [VAL_W-1:0] IDLE_VAL    = 32'h0000_0000,
  parameter logic [VAL_W-1:0] BLINK_VAL   = 32'h8888_8888,
  localparam int             SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [NUM_SRC*VAL_W-1:0] src_val_in,
  input  logic [NUM_SRC-1:0]       src_en_in,
  input  logic [NUM_SRC-1:0]       alert_req_in,
  output logic [NUM_SRC-1:0]       alert_ack_out,
  input  logic                     freeze_in,
  output logic [VAL_W-1:0]         val_out,
  output logic [SW-1:0]            cur_src_out,
  output logic                     alert_active_out,
  output sched_state_t             state_out
);

  localparam int DW_W = cnt_w(DWELL_CYCLES);
  localparam int AL_W = cnt_w(ALERT_CYCLES);
  localparam int BL_W = cnt_w(BLINK_HALF);

  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
  localparam logic [AL_W-1:0] ALERT_LAST = AL_W'(ALERT_CYCLES - 1);
  localparam logic [BL_W-1:0] BLINK_LAST = BL_W'(BLINK_HALF - 1);

  sched_state_t        state_q, state_d;
  logic [SW-1:0]       cur_q, cur_d;
  logic [DW_W-1:0]     dwell_q, dwell_d;
  logic [AL_W-1:0]     alert_q, alert_d;
  logic [BL_W-1:0]     blink_q, blink_d;
  logic                phase_q, phase_d;
  logic [NUM_SRC-1:0]  ack_d;
  logic [VAL_W-1:0]    val_d;
  logic [VAL_W-1:0]    sel_val;
  logic                take_alert;

  logic [SW-1:0]       adv_idx, low_en_idx, alert_idx;
  logic                adv_found, en_found, alert_found;

  // Next enabled source after the one currently shown.
  rr_next_pick #(.N(NUM_SRC)) u_adv_pick (
    .mask  (src_en_in),
    .start (cur_q),
    .idx   (adv_idx),
    .found (adv_found)
  );

  rr_next_pick #(.N(NUM_SRC)) u_low_en_pick (
    .mask  (src_en_in),
    .start (SW'(NUM_SRC - 1)),
    .idx   (low_en_idx),
    .found (en_found)
  );

  rr_next_pick #(.N(NUM_SRC)) u_alert_pick (
    .mask  (alert_req_in),
    .start (SW'(NUM_SRC - 1)),
    .idx   (alert_idx),
    .found (alert_found)
  );

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    dwell_d    = dwell_q;
    alert_d    = alert_q;
    blink_d    = blink_q;
    phase_d    = phase_q;
    ack_d      = '0;
    take_alert = 1'b0;

    case (state_q)
      IDLE: begin
        if (alert_found) begin
          take_alert = 1'b1;
        end else if (en_found) begin
          state_d = ROTATE;
          cur_d   = low_en_idx;
          dwell_d = '0;
        end
      end

      ROTATE: begin
        if (alert_found) begin
          take_alert = 1'b1;
        end else if (!adv_found) begin
          state_d = IDLE;
          dwell_d = '0;
        end else if (!src_en_in[cur_q]) begin
          // A disabled source is left at once, even while frozen.
          cur_d   = adv_idx;
          dwell_d = '0;
        end else if (!freeze_in) begin
          if (dwell_q == DWELL_LAST) begin
            cur_d   = adv_idx;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + DW_W'(1);
          end
        end
      end

      ALERT: begin
        if (alert_q == ALERT_LAST) begin
          alert_d = '0;
          blink_d = '0;
          phase_d = 1'b1;
          if (alert_found) begin
            take_alert = 1'b1;
          end else if (en_found) begin
            state_d = ROTATE;
            dwell_d = '0;
            cur_d   = src_en_in[cur_q] ? cur_q : adv_idx;
          end else begin
            // cur_src keeps the last alerting source while idle.
            state_d = IDLE;
          end
        end else begin
          alert_d = alert_q + AL_W'(1);
          if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            phase_d = ~phase_q;
          end else begin
            blink_d = blink_q + BL_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Alert acceptance overrides every other transition decided above.
    if (take_alert) begin
      state_d = ALERT;
      cur_d   = alert_idx;
      ack_d   = NUM_SRC'(1) << alert_idx;
      alert_d = '0;
      blink_d = '0;
      phase_d = 1'b1;
      dwell_d = '0;
    end
  end

  // Output value is selected from the next-cycle source, so it is live with
  // exactly one cycle of latency and always agrees with cur_src_out.
  always_comb begin
    sel_val = src_val_in[int'(cur_d)*VAL_W +: VAL_W];
    case (state_d)
      ROTATE:  val_d = sel_val;
      ALERT:   val_d = phase_d ? sel_val : BLINK_VAL;
      default: val_d = IDLE_VAL;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q          <= IDLE;
      cur_q            <= '0;
      dwell_q          <= '0;
      alert_q          <= '0;
      blink_q          <= '0;
      phase_q          <= 1'b1;
      val_out          <= IDLE_VAL;
      alert_ack_out    <= '0;
      alert_active_out <= 1'b0;
    end else begin
      state_q          <= state_d;
      cur_q            <= cur_d;
      dwell_q          <= dwell_d;
      alert_q          <= alert_d;
      blink_q          <= blink_d;
      phase_q          <= phase_d;
      val_out          <= val_d;
      alert_ack_out    <= ack_d;
      alert_active_out <= (state_d == ALERT);
    end
  end

  assign cur_src_out = cur_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_seven_seg_display_scheduler.sv
// Self-checking bench: per-cycle vector table with an expected-value queue,
// plus hand-written asynchronous reset checks.
module tb_seven_seg_display_scheduler;
  import seven_seg_pkg::*;

  localparam int NS = 4;
  localparam int EW = NS + 1 + 2 + 32;

  logic              clk_in;
  logic              rst_n_in;
  logic [NS*32-1:0]  src_val_in;
  logic [NS-1:0]     src_en_in;
  logic [NS-1:0]     alert_req_in;
  logic [NS-1:0]     alert_ack_out;
  logic              freeze_in;
  logic [31:0]       val_out;
  logic [1:0]        cur_src_out;
  logic              alert_active_out;
  sched_state_t      state_out;

  seven_seg_display_scheduler #(
    .NUM_SRC      (NS),
    .DWELL_CYCLES (8),
    .ALERT_CYCLES (12),
    .BLINK_HALF   (3),
    .IDLE_VAL     (32'h0000_0000),
    .BLINK_VAL    (32'h8888_8888)
  ) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .src_val_in       (src_val_in),
    .src_en_in        (src_en_in),
    .alert_req_in     (alert_req_in),
    .alert_ack_out    (alert_ack_out),
    .freeze_in        (freeze_in),
    .val_out          (val_out),
    .cur_src_out      (cur_src_out),
    .alert_active_out (alert_active_out),
    .state_out        (state_out)
  );

  // clock / reset
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  typedef struct {
    logic [3:0]  en;
    logic [3:0]  req;
    logic        frz;
    logic [31:0] v0;
    int          n;
    logic [31:0] val;
    logic [1:0]  cur;
    logic [3:0]  ack;
    logic        act;
  } vec_t;

  vec_t          vecs[$];
  logic [EW-1:0] exp_q[$];
  int            errors = 0;
  int            checks = 0;

  localparam logic [31:0] BV = 32'h8888_8888;

  task automatic add_row(input logic [3:0] en, input logic [3:0] req, input logic frz,
                         input logic [31:0] v0, input int n, input logic [31:0] val,
                         input logic [1:0] cur, input logic [3:0] ack, input logic act);
    vec_t r;
    r.en = en; r.req = req; r.frz = frz; r.v0 = v0; r.n = n;
    r.val = val; r.cur = cur; r.ack = ack; r.act = act;
    vecs.push_back(r);
  endtask

  // scoreboard: pop one expectation and compare against the registered outputs
  task automatic check_out(input string name, input int tag);
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    checks++;
    got = {alert_ack_out, alert_active_out, cur_src_out, val_out};
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s[%0d]: expected queue empty", name, tag);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL %s[%0d]: got ack=%b act=%b cur=%0d val=%h, want ack=%b act=%b cur=%0d val=%h",
                 name, tag, got[38:35], got[34], got[33:32], got[31:0],
                 e[38:35], e[34], e[33:32], e[31:0]);
      end
    end
  endtask

  task automatic check_state(input string name, input sched_state_t want);
    checks++;
    if (state_out !== want) begin
      errors++;
      $display("FAIL %s: got state=%0d, want state=%0d", name, state_out, want);
    end
  endtask

  // driver: apply one table row for its cycle count
  task automatic run_row(input vec_t r, input int idx);
    for (int i = 0; i < r.n; i++) begin
      @(negedge clk_in);
      src_en_in        = r.en;
      alert_req_in     = r.req;
      freeze_in        = r.frz;
      src_val_in[31:0] = r.v0;
      exp_q.push_back({r.ack, r.act, r.cur, r.val});
      @(posedge clk_in);
      #1;
      check_out("row", idx);
    end
  endtask

  localparam logic [3:0] E = 4'b1011;
  int split;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_in     = 1'b0;
    src_val_in   = {32'h44, 32'h33, 32'h22, 32'h11};
    src_en_in    = '0;
    alert_req_in = '0;
    freeze_in    = 1'b0;

    // idle after reset, then rotation 0,1,3,0 with source 2 skipped
    add_row(4'b0000, 4'b0000, 0, 32'h11, 3, 32'h0,  0, 4'b0, 0);
    add_row(E, 4'b0000, 0, 32'h11, 8, 32'h11, 0, 4'b0, 0);
    add_row(E, 4'b0000, 0, 32'h11, 8, 32'h22, 1, 4'b0, 0);
    add_row(E, 4'b0000, 0, 32'h11, 8, 32'h44, 3, 4'b0, 0);
    add_row(E, 4'b0000, 0, 32'h11, 8, 32'h11, 0, 4'b0, 0);
    add_row(E, 4'b0000, 0, 32'h11, 1, 32'h22, 1, 4'b0, 0);
    // freeze holds source 1; disabling it still advances to 3
    add_row(E,       4'b0000, 1, 32'h11, 20, 32'h22, 1, 4'b0, 0);
    add_row(4'b1001, 4'b0000, 1, 32'h11, 1,  32'h44, 3, 4'b0, 0);
    add_row(4'b1001, 4'b0000, 1, 32'h11, 5,  32'h44, 3, 4'b0, 0);
    add_row(E,       4'b0000, 0, 32'h11, 7,  32'h44, 3, 4'b0, 0);
    add_row(E,       4'b0000, 0, 32'h11, 1,  32'h11, 0, 4'b0, 0);
    // alert 1 preempts, blinks 3/3 for 12 cycles; alert 2 served next
    add_row(E, 4'b0110, 0, 32'h11, 1, 32'h22, 1, 4'b0010, 1);
    add_row(E, 4'b0100, 0, 32'h11, 2, 32'h22, 1, 4'b0000, 1);
    add_row(E, 4'b0100, 0, 32'h11, 3, BV,     1, 4'b0000, 1);
    add_row(E, 4'b0100, 0, 32'h11, 3, 32'h22, 1, 4'b0000, 1);
    add_row(E, 4'b0100, 0, 32'h11, 3, BV,     1, 4'b0000, 1);
    add_row(E, 4'b0100, 0, 32'h11, 1, 32'h33, 2, 4'b0100, 1);
    add_row(E, 4'b0000, 0, 32'h11, 2, 32'h33, 2, 4'b0000, 1);
    add_row(E, 4'b0000, 0, 32'h11, 3, BV,     2, 4'b0000, 1);
    add_row(E, 4'b0000, 0, 32'h11, 3, 32'h33, 2, 4'b0000, 1);
    add_row(E, 4'b0000, 0, 32'h11, 3, BV,     2, 4'b0000, 1);
    add_row(E, 4'b0000, 0, 32'h11, 8, 32'h44, 3, 4'b0000, 0);
    add_row(E, 4'b0000, 0, 32'h11, 1, 32'h11, 0, 4'b0000, 0);
    // live value change mid-dwell, dwell length unchanged
    add_row(E, 4'b0000, 0, 32'h55, 4, 32'h55, 0, 4'b0000, 0);
    add_row(E, 4'b0000, 0, 32'h66, 3, 32'h66, 0, 4'b0000, 0);
    add_row(E, 4'b0000, 0, 32'h66, 1, 32'h22, 1, 4'b0000, 0);
    split = vecs.size();
    // after mid-run reset: idle, then alert from a disabled source
    add_row(4'b0000, 4'b0000, 0, 32'h11, 3, 32'h0,  0, 4'b0000, 0);
    add_row(4'b0000, 4'b1000, 0, 32'h11, 1, 32'h44, 3, 4'b1000, 1);
    add_row(4'b0000, 4'b0000, 0, 32'h11, 2, 32'h44, 3, 4'b0000, 1);
    add_row(4'b0000, 4'b0000, 0, 32'h11, 3, BV,     3, 4'b0000, 1);
    add_row(4'b0000, 4'b0000, 0, 32'h11, 3, 32'h44, 3, 4'b0000, 1);
    add_row(4'b0000, 4'b0000, 0, 32'h11, 3, BV,     3, 4'b0000, 1);
    add_row(4'b0000, 4'b0000, 0, 32'h11, 3, 32'h0,  3, 4'b0000, 0);

    // reset state
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    exp_q.push_back('0);
    check_out("reset", 0);
    check_state("reset_state", IDLE);
    rst_n_in = 1'b1;

    for (int i = 0; i < split; i++) run_row(vecs[i], i);

    // asynchronous reset mid-rotation: outputs clear with no clock edge
    check_state("pre_reset_state", ROTATE);
    #1;
    src_en_in = '0;
    rst_n_in  = 1'b0;
    #1;
    exp_q.push_back('0);
    check_out("async_reset", 0);
    check_state("async_reset_state", IDLE);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    for (int i = split; i < vecs.size(); i++) run_row(vecs[i], i);
    check_state("final_state", IDLE);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expectations never compared", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_display_scheduler.md
Name: seven_seg_display_scheduler

Overview:
Shares the single 8-digit seven-segment display between NUM_SRC value producers, for example score, timer, elixir count and debug. It rotates round-robin through the enabled sources, holding each for a fixed dwell time. A source may raise an alert that preempts rotation and blinks its value for a fixed time. The val_out output feeds val_in of seven_segment_controller directly.

Parameters:
NUM_SRC, 4, number of requesting sources (2..8)
DWELL_CYCLES, 100_000_000, clocks each source is shown during rotation (1 s at 100 MHz)
ALERT_CYCLES, 50_000_000, total clocks an alert is shown
BLINK_HALF, 6_250_000, clocks per blink phase during an alert
IDLE_VAL, 32'h0000_0000, value shown when no source is enabled and no alert is active
BLINK_VAL, 32'h8888_8888, value shown in the "off" blink phase (all segments lit)

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  reset, asynchronous, active-low
src_val_in  in  NUM_SRC*32  packed source values; source i occupies bits [32*i+31:32*i]
src_en_in  in  NUM_SRC  source i participates in rotation while high
alert_req_in  in  NUM_SRC  level request; held by the source until acknowledged
alert_ack_out  out  NUM_SRC  one-cycle pulse on the cycle an alert is accepted
freeze_in  in  1  while high, the dwell counter holds (rotation paused); the alert timer does not hold
val_out  out  32  value to the display controller
cur_src_out  out  $clog2(NUM_SRC)  index of the source currently shown
alert_active_out  out  1  high while in ALERT

Behaviour:
- Reset is asynchronous on rst_n_in low. Reset values: state=IDLE, val_out=IDLE_VAL, cur_src_out=0, alert_ack_out=0, alert_active_out=0, all counters=0.
- All outputs are registered.
- States: IDLE, ROTATE, ALERT.
- Alert priority: in IDLE or ROTATE, if any alert_req_in bit is high, the lowest index wins.
  - Next cycle: state=ALERT, cur_src_out=winner, alert_ack_out[winner]=1 for exactly 1 cycle.
  - The blink counter and alert counter are cleared.
  - Alert takes precedence over every other transition in the same cycle.
- IDLE:
  - No enabled source: stay in IDLE, val_out=IDLE_VAL.
  - Otherwise go to ROTATE with cur_src = lowest enabled index and dwell=0.
- ROTATE:
  - val_out <= src_val_in[cur_src] every cycle (live value, 1-cycle latency).
  - The dwell counter increments unless freeze_in is high.
  - At dwell==DWELL_CYCLES-1: cur_src becomes the next enabled index after cur_src, wrapping modulo NUM_SRC, and dwell=0. If cur_src is the only enabled source, it stays and dwell=0.
  - If src_en_in[cur_src] drops: advance to the next enabled source on the next cycle with dwell=0, regardless of freeze_in.
  - If no source is enabled: go to IDLE.
- ALERT:
  - The blink counter wraps at BLINK_HALF-1 and toggles the phase each time it wraps. The phase starts "on".
  - Phase on: val_out <= src_val_in[cur_src]. Phase off: val_out <= BLINK_VAL.
  - Additional alert requests are ignored, with no ack, until ALERT exits. They are served afterwards in priority order.
  - At alert counter==ALERT_CYCLES-1:
    - If a pending alert exists, go directly to ALERT for that alert and ack it.
    - Else if any source is enabled, go to ROTATE with dwell=0. cur_src stays on the alerting source if it is enabled, otherwise moves to the next enabled source.
    - Else go to IDLE.
  - An alert from a disabled source is legal and shown normally.
- Counter widths: $clog2 of their respective maximum values. No counter ever exceeds its terminal value.
- A source vector change takes effect on val_out exactly 1 cycle later. Nothing is latched at selection time.

Decomposition:
- Package seven_seg_pkg holds:
  - sched_state_t enum {IDLE, ROTATE, ALERT}
  - DIGITS=8
  - VAL_W=32
- Sub-module rr_next_pick: a combinational priority search. Inputs: mask and start index. Outputs: first set index at or after start+1, wrapping, plus a found flag. It is used for rotation advance. A second instance with start=NUM_SRC-1 finds the lowest set bit, used for both IDLE exit and alert selection.

Test Plan:
Bench parameters for all scenarios: NUM_SRC=4, DWELL_CYCLES=8, ALERT_CYCLES=12, BLINK_HALF=3.
1. Reset mid-operation: assert rst_n_in low during ROTATE -> outputs go to their reset values immediately with no clock edge, val_out=0. After release with src_en_in=0 -> stays IDLE, val_out=0.
2. Rotation: src_en_in=4'b1011, values 32'h11/22/33/44 -> val_out shows 11 for 8 cycles, then 22, then 44 (source 2 skipped), then 11 again (wrap). cur_src_out sequence is 0,1,3,0.
3. Freeze and disable: with freeze_in high at source 1 -> source 1 is held indefinitely. Then drop src_en_in[1] -> advance to source 3 the next cycle, even while frozen.
4. Alert preemption: during ROTATE, raise alert_req_in=4'b0110 -> alert_ack_out=4'b0010 for 1 cycle. val_out alternates 22 for 3 cycles, 8888_8888 for 3 cycles, repeating, for 12 cycles. Then source 2 is acked immediately. After its 12 cycles, return to ROTATE at source 3 (source 2 disabled) with dwell=0.
5. Alert from disabled source with none enabled: src_en_in=0, alert_req_in[3]=1 -> ALERT shows source 3 blinking for 12 cycles, then IDLE with val_out=IDLE_VAL.
6. Live value tracking: change src_val_in for the current source mid-dwell -> val_out follows exactly 1 cycle later, and dwell timing is unaffected.
